// File: rtl/matrix_gen_scheduler_pkg.sv
// Shared constants for the matrix generator scheduler: FSM encoding, error codes
// and the generator's fixed matrix geometry.
package matrix_gen_scheduler_pkg;

    localparam int MAX_DIM = 5;
    localparam int TIMER_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIM     = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic dim_legal(input logic [2:0] d);
        return (d != 3'd0) && (d <= 3'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_gen_scheduler_walker.sv
// Holds the snapshot of one generated matrix and walks its valid row x col window
// in row-major order, presenting packed address, element value and last flag.
module matrix_snapshot_walker
    import matrix_gen_scheduler_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic                               step,
    input  logic [2:0]                         row,
    input  logic [2:0]                         col,
    input  logic [MAX_DIM*MAX_DIM*WIDTH-1:0]   flat_in,
    output logic [4:0]                         addr,
    output logic [WIDTH-1:0]                   data,
    output logic                               last
);

    logic [MAX_DIM*MAX_DIM*WIDTH-1:0] snap_q, snap_d;
    logic [2:0] r_q, r_d;
    logic [2:0] c_q, c_d;
    logic [4:0] idx_s;

    assign last  = (r_q == row - 3'd1) && (c_q == col - 3'd1);
    assign idx_s = 5'(r_q) * 5'(MAX_DIM) + 5'(c_q);
    // Packed address uses the shadowed column count, not the generator stride.
    assign addr  = 5'(r_q) * 5'(col) + 5'(c_q);
    assign data  = snap_q[idx_s*WIDTH +: WIDTH];

    // Next-state for snapshot and row/col counters.
    always_comb begin
        snap_d = snap_q;
        r_d    = r_q;
        c_d    = c_q;
        if (load) begin
            snap_d = flat_in;
            r_d    = 3'd0;
            c_d    = 3'd0;
        end else if (step) begin
            if (last) begin
                r_d = 3'd0;
                c_d = 3'd0;
            end else if (c_q == col - 3'd1) begin
                r_d = r_q + 3'd1;
                c_d = 3'd0;
            end else begin
                c_d = c_q + 3'd1;
            end
        end else begin
            snap_d = snap_q;
        end
    end

    // Snapshot and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            r_q    <= 3'd0;
            c_q    <= 3'd0;
        end else begin
            snap_q <= snap_d;
            r_q    <= r_d;
            c_q    <= c_d;
        end
    end

endmodule

// File: rtl/matrix_gen_scheduler.sv
// Fills COUNT storage slots with generated matrices: drives the generator's
// level handshake, snapshots each result and streams the valid elements out.
module matrix_gen_scheduler
    import matrix_gen_scheduler_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_SLOTS   = 4,
    parameter int SLOT_W      = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [2:0]                       cfg_row,
    input  logic [2:0]                       cfg_col,
    input  logic [WIDTH-1:0]                 cfg_min,
    input  logic [WIDTH-1:0]                 cfg_max,
    input  logic [SLOT_W:0]                  cfg_count,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [1:0]                       err_code,
    output logic [2:0]                       gen_row,
    output logic [2:0]                       gen_col,
    output logic [WIDTH-1:0]                 gen_min,
    output logic [WIDTH-1:0]                 gen_max,
    output logic                             gen_update_en,
    input  logic                             gen_update_done,
    input  logic [MAX_DIM*MAX_DIM*WIDTH-1:0] gen_matrix_flat,
    output logic                             wr_en,
    output logic [SLOT_W-1:0]                wr_slot,
    output logic [4:0]                       wr_addr,
    output logic [WIDTH-1:0]                 wr_data,
    output logic                             wr_last
);

    logic [2:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc_s;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [2:0]         row_q, row_d, col_q, col_d;
    logic [WIDTH-1:0]   min_q, min_d, max_q, max_d;
    logic [SLOT_W:0]    count_q, count_d;
    logic               busy_q, busy_d, en_q, en_d, done_q, done_d, err_q, err_d;
    logic               load_s, step_s, walk_last_s, count_ok_s, last_slot_s, timeout_s;

    assign count_ok_s  = (count_q != '0) && (count_q <= (SLOT_W+1)'(MAX_SLOTS));
    assign last_slot_s = ({1'b0, slot_q} == count_q - (SLOT_W+1)'(1));
    assign timer_inc_s = timer_q + TIMER_W'(1);
    assign timeout_s   = (timer_inc_s == TIMER_W'(TIMEOUT_CYC));

    // FSM next-state, shadow capture and walker control.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        slot_d     = slot_q;
        err_code_d = err_code_q;
        row_d      = row_q;
        col_d      = col_q;
        min_d      = min_q;
        max_d      = max_q;
        count_d    = count_q;
        load_s     = 1'b0;
        step_s     = 1'b0;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        row_d      = cfg_row;
                        col_d      = cfg_col;
                        min_d      = cfg_min;
                        max_d      = cfg_max;
                        count_d    = cfg_count;
                        err_code_d = ERR_NONE;
                        state_d    = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (!dim_legal(row_q) || !dim_legal(col_q) || !count_ok_s) begin
                        err_code_d = ERR_DIM;
                        state_d    = ST_ERR;
                    end else if (min_q > max_q) begin
                        err_code_d = ERR_RANGE;
                        state_d    = ST_ERR;
                    end else begin
                        slot_d  = '0;
                        timer_d = '0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    timer_d = timer_inc_s;
                    if (gen_update_done) begin
                        load_s  = 1'b1;
                        state_d = ST_WRITE;
                    end else if (timeout_s) begin
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_ERR;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WRITE: begin
                    step_s = 1'b1;
                    if (walk_last_s) begin
                        timer_d = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                // Generator must drop done before it is requested again.
                ST_RELEASE: begin
                    timer_d = timer_inc_s;
                    if (!gen_update_done) begin
                        if (last_slot_s) begin
                            state_d = ST_DONE;
                        end else begin
                            slot_d  = slot_q + SLOT_W'(1);
                            timer_d = '0;
                            state_d = ST_REQ;
                        end
                    end else if (timeout_s) begin
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_ERR;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERR:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        en_d   = (state_d == ST_REQ);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            slot_q     <= '0;
            err_code_q <= ERR_NONE;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            min_q      <= '0;
            max_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            slot_q     <= slot_d;
            err_code_q <= err_code_d;
            row_q      <= row_d;
            col_q      <= col_d;
            min_q      <= min_d;
            max_q      <= max_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    matrix_snapshot_walker #(
        .WIDTH (WIDTH)
    ) u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .step    (step_s),
        .row     (row_q),
        .col     (col_q),
        .flat_in (gen_matrix_flat),
        .addr    (wr_addr),
        .data    (wr_data),
        .last    (walk_last_s)
    );

    // An abort arriving on a write cycle kills that write.
    assign wr_en         = (state_q == ST_WRITE) && !abort;
    assign wr_last       = wr_en && walk_last_s;
    assign wr_slot       = slot_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign gen_update_en = en_q;
    assign gen_row       = row_q;
    assign gen_col       = col_q;
    assign gen_min       = min_q;
    assign gen_max       = max_q;

endmodule
